// File: rtl/addsub_share_arb.sv
// Round-robin arbiter sharing one add/subtract datapath between two requesters,
// each with its own registered one-entry response slot.
module addsub_share_arb #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic             req_sub_0,
    input  logic             req_sub_1,
    output logic             rsp_valid_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_0,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_sum_0,
    output logic [WIDTH-1:0] rsp_sum_1,
    output logic             rsp_cout_0,
    output logic             rsp_cout_1,
    output logic             rsp_ovf_0,
    output logic             rsp_ovf_1,
    output logic [15:0]      op_count
);

    logic             elig_0, elig_1;
    logic             grant_0, grant_1;
    logic             last_grant;
    logic [WIDTH-1:0] op_a, op_b, sum;
    logic             op_sub, cout, ovf;
    logic [WIDTH:0]   r17;

    // A slot can accept when empty or being drained this same cycle.
    always_comb begin
        elig_0  = ~rst & req_valid_0 & (~rsp_valid_0 | rsp_ready_0);
        elig_1  = ~rst & req_valid_1 & (~rsp_valid_1 | rsp_ready_1);
        grant_0 = elig_0 & (~elig_1 | last_grant);
        grant_1 = elig_1 & (~elig_0 | ~last_grant);
        req_ready_0 = grant_0;
        req_ready_1 = grant_1;
    end

    always_comb begin
        op_a   = grant_1 ? req_a_1   : req_a_0;
        op_b   = grant_1 ? req_b_1   : req_b_0;
        op_sub = grant_1 ? req_sub_1 : req_sub_0;
        if (op_sub) begin
            r17 = {1'b0, op_a} - {1'b0, op_b};
        end else begin
            r17 = {1'b0, op_a} + {1'b0, op_b};
        end
        sum  = r17[WIDTH-1:0];
        cout = r17[WIDTH];
        if (op_sub) begin
            ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
        end else begin
            ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_0 <= 1'b0;
            rsp_sum_0   <= '0;
            rsp_cout_0  <= 1'b0;
            rsp_ovf_0   <= 1'b0;
        end else if (grant_0) begin
            rsp_valid_0 <= 1'b1;
            rsp_sum_0   <= sum;
            rsp_cout_0  <= cout;
            rsp_ovf_0   <= ovf;
        end else if (rsp_ready_0) begin
            rsp_valid_0 <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_1 <= 1'b0;
            rsp_sum_1   <= '0;
            rsp_cout_1  <= 1'b0;
            rsp_ovf_1   <= 1'b0;
        end else if (grant_1) begin
            rsp_valid_1 <= 1'b1;
            rsp_sum_1   <= sum;
            rsp_cout_1  <= cout;
            rsp_ovf_1   <= ovf;
        end else if (rsp_ready_1) begin
            rsp_valid_1 <= 1'b0;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            op_count   <= '0;
        end else if (grant_0 | grant_1) begin
            last_grant <= grant_1;
            op_count   <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_addsub_share_arb.sv
// Randomized and directed bench for addsub_share_arb, checked every cycle
// against a behavioural model of the arbitration and arithmetic rules.
module tb_addsub_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv [2];
    logic        rr [2];
    logic [15:0] ra [2];
    logic [15:0] rb [2];
    logic        rs [2];
    logic        rdy_0, rdy_1, vld_0, vld_1, co_0, co_1, ov_0, ov_1;
    logic [15:0] sm_0, sm_1, cnt;

    int total = 0;
    int bad = 0;

    // model state
    logic        m_v [2] = '{1'b0, 1'b0};
    logic [15:0] m_s [2] = '{16'h0, 16'h0};
    logic        m_c [2] = '{1'b0, 1'b0};
    logic        m_o [2] = '{1'b0, 1'b0};
    int          m_last = 1;
    logic [15:0] m_cnt = 16'h0;

    always #5 clk = ~clk;

    addsub_share_arb #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(rv[0]), .req_valid_1(rv[1]),
        .req_ready_0(rdy_0), .req_ready_1(rdy_1),
        .req_a_0(ra[0]), .req_a_1(ra[1]),
        .req_b_0(rb[0]), .req_b_1(rb[1]),
        .req_sub_0(rs[0]), .req_sub_1(rs[1]),
        .rsp_valid_0(vld_0), .rsp_valid_1(vld_1),
        .rsp_ready_0(rr[0]), .rsp_ready_1(rr[1]),
        .rsp_sum_0(sm_0), .rsp_sum_1(sm_1),
        .rsp_cout_0(co_0), .rsp_cout_1(co_1),
        .rsp_ovf_0(ov_0), .rsp_ovf_1(ov_1),
        .op_count(cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: unsigned range for carry, signed range for overflow.
    function automatic void calc(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                 output logic [15:0] s, output logic c, output logic o);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int ur = sub ? ua - ub : ua + ub;
        int sr = sub ? sa - sb : sa + sb;
        logic [31:0] ur_bits = ur;
        s = ur_bits[15:0];
        c = sub ? (ua < ub) : (ur > 65535);
        o = (sr > 32767) || (sr < -32768);
    endfunction

    // Which requester should win right now, or -1 for none.
    function automatic int winner();
        bit e [2];
        for (int i = 0; i < 2; i++)
            e[i] = !rst && rv[i] && (!m_v[i] || rr[i]);
        if (e[0] && e[1]) return (m_last == 0) ? 1 : 0;
        if (e[0]) return 0;
        if (e[1]) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_v[i] = 1'b0; m_s[i] = 16'h0; m_c[i] = 1'b0; m_o[i] = 1'b0;
            end
            m_last = 1;
            m_cnt  = 16'h0;
        end else begin
            int w;
            w = winner();
            for (int i = 0; i < 2; i++) begin
                if (w == i) begin
                    calc(ra[i], rb[i], rs[i], m_s[i], m_c[i], m_o[i]);
                    m_v[i] = 1'b1;
                end else if (rr[i]) begin
                    m_v[i] = 1'b0;
                end
            end
            if (w >= 0) begin
                m_last = w;
                m_cnt  = m_cnt + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        w = winner();
        chk("req_ready_0", {31'b0, rdy_0}, {31'b0, w == 0});
        chk("req_ready_1", {31'b0, rdy_1}, {31'b0, w == 1});
        chk("rsp_valid_0", {31'b0, vld_0}, {31'b0, m_v[0]});
        chk("rsp_valid_1", {31'b0, vld_1}, {31'b0, m_v[1]});
        chk("rsp_sum_0", {16'b0, sm_0}, {16'b0, m_s[0]});
        chk("rsp_sum_1", {16'b0, sm_1}, {16'b0, m_s[1]});
        chk("rsp_cout_0", {31'b0, co_0}, {31'b0, m_c[0]});
        chk("rsp_cout_1", {31'b0, co_1}, {31'b0, m_c[1]});
        chk("rsp_ovf_0", {31'b0, ov_0}, {31'b0, m_o[0]});
        chk("rsp_ovf_1", {31'b0, ov_1}, {31'b0, m_o[1]});
        chk("op_count", {16'b0, cnt}, {16'b0, m_cnt});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic sub);
        rv[i] = v; ra[i] = a; rb[i] = b; rs[i] = sub;
    endtask

    logic [15:0] ca [4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000};
    logic [15:0] cb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
    logic        cs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [4] = '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF};
    logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        eo [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        bit held [2];
        int guard;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_req(i, 1'b0, 16'h0, 16'h0, 1'b0);
            rr[i] = 1'b0;
        end
        tick(); tick();
        rst = 1'b0;

        // contention: strict alternation starting with requester 0
        rr[0] = 1'b1; rr[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1'b1, 16'(k * 16'h0011), 16'h0100, 1'b0);
            set_req(1, 1'b1, 16'h1000, 16'(k), 1'b1);
            #1;
            chk("rr_grant0", {31'b0, rdy_0}, {31'b0, (k % 2) == 0});
            chk("rr_grant1", {31'b0, rdy_1}, {31'b0, (k % 2) == 1});
            tick();
        end
        chk("count6", {16'b0, cnt}, 32'd6);
        chk("slot0_last", {16'b0, sm_0}, 32'h0144);
        chk("slot1_last", {16'b0, sm_1}, 32'h0FFB);

        // asynchronous reset with slot 0 full and a request pending
        rr[0] = 1'b0; rv[1] = 1'b0;
        set_req(0, 1'b1, 16'h0005, 16'h0005, 1'b0);
        tick();
        chk("full_before_rst", {31'b0, vld_0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_ready0", {31'b0, rdy_0}, 32'd0);
        chk("rst_valid0", {31'b0, vld_0}, 32'd0);
        chk("rst_sum0", {16'b0, sm_0}, 32'd0);
        chk("rst_count", {16'b0, cnt}, 32'd0);
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 16'h0001, 16'h0002, 1'b0);
        #1;
        chk("post_rst_ready0", {31'b0, rdy_0}, 32'd1);
        tick();
        chk("post_rst_sum", {16'b0, sm_0}, 32'h0003);
        chk("post_rst_cout", {31'b0, co_0}, 32'd0);
        chk("post_rst_ovf", {31'b0, ov_0}, 32'd0);
        chk("post_rst_count", {16'b0, cnt}, 32'd1);
        chk("model_pin_count", {16'b0, m_cnt}, 32'd1);

        // arithmetic corners on port 0
        rr[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, ca[k], cb[k], cs[k]);
            tick();
            chk("corner_sum", {16'b0, sm_0}, {16'b0, es[k]});
            chk("corner_cout", {31'b0, co_0}, {31'b0, ec[k]});
            chk("corner_ovf", {31'b0, ov_0}, {31'b0, eo[k]});
            chk("model_pin_sum", {16'b0, m_s[0]}, {16'b0, es[k]});
            chk("model_pin_ovf", {31'b0, m_o[0]}, {31'b0, eo[k]});
        end
        rv[0] = 1'b0;
        tick();

        // backpressure on slot 1
        rr[1] = 1'b0;
        set_req(1, 1'b1, 16'h0020, 16'h0003, 1'b0);
        tick();
        chk("slot1_full", {31'b0, vld_1}, 32'd1);
        set_req(0, 1'b1, 16'h0040, 16'h0001, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready1", {31'b0, rdy_1}, 32'd0);
            chk("bp_ready0", {31'b0, rdy_0}, 32'd1);
            tick();
        end
        rr[1] = 1'b1;
        #1;
        chk("bp_release_ready1", {31'b0, rdy_1}, 32'd1);
        chk("bp_release_ready0", {31'b0, rdy_0}, 32'd0);
        tick();
        rv[1] = 1'b0;

        // drain and fill on port 0
        for (int k = 1; k <= 4; k++) begin
            set_req(0, 1'b1, 16'h0100, 16'(k), 1'b0);
            #1;
            chk("df_ready0", {31'b0, rdy_0}, 32'd1);
            tick();
            chk("df_valid0", {31'b0, vld_0}, 32'd1);
            chk("df_sum0", {16'b0, sm_0}, 32'h0100 + 32'(k));
        end
        rv[0] = 1'b0;
        tick();

        // randomized traffic; operands held while valid and not accepted
        held[0] = 0; held[1] = 0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!held[i])
                    set_req(i, $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                            1'($urandom_range(0, 1)));
                rr[i] = $urandom_range(0, 2) != 0;
            end
            #1;
            held[0] = rv[0] && !rdy_0;
            held[1] = rv[1] && !rdy_1;
            tick();
        end

        // run the counter up to its wrap point
        rr[0] = 1'b1; rr[1] = 1'b1;
        set_req(0, 1'b1, 16'h1234, 16'h4321, 1'b0);
        set_req(1, 1'b1, 16'h8000, 16'h7FFF, 1'b1);
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        chk("wrap_reached", {31'b0, guard < 70000}, 32'd1);
        rv[1] = 1'b0;
        chk("count_ffff", {16'b0, cnt}, 32'h0000FFFF);
        tick();
        chk("count_wrap", {16'b0, cnt}, 32'd0);
        rv[0] = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
